// File: rtl/cosim_uart_link.sv
// Buffered UART transceiver for the co-simulation host link: rx synchroniser, glitch-rejecting RX,
// RX/TX FIFOs and sticky error flags. Define COSIM_UART_PARITY_EN for even parity in both directions.
module cosim_uart_link #(
  parameter int unsigned CLK_FREQ      = 50_000_000,
  parameter int unsigned BAUD_RATE     = 10_000_000,
  parameter int unsigned SYNC_STAGES   = 3,
  parameter int unsigned DATA_BITS     = 8,
  parameter int unsigned RX_FIFO_DEPTH = 16,
  parameter int unsigned TX_FIFO_DEPTH = 16
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               rx_i,
  output logic                               tx_o,
  output logic [DATA_BITS-1:0]               rx_data_o,
  output logic                               rx_valid_o,
  input  logic                               rx_ready_i,
  input  logic [DATA_BITS-1:0]               tx_data_i,
  input  logic                               tx_valid_i,
  output logic                               tx_ready_o,
  output logic [$clog2(RX_FIFO_DEPTH+1)-1:0] rx_count_o,
  output logic                               tx_busy_o,
  output logic                               frame_err_o,
  output logic                               overflow_o,
  input  logic                               err_clear_i
`ifdef COSIM_UART_PARITY_EN
  ,
  output logic                               parity_err_o
`endif
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W        = $clog2(DATA_BITS);
  localparam int unsigned RX_AW        = $clog2(RX_FIFO_DEPTH);
  localparam int unsigned RX_CW        = $clog2(RX_FIFO_DEPTH + 1);
  localparam int unsigned TX_AW        = $clog2(TX_FIFO_DEPTH);
  localparam int unsigned TX_CW        = $clog2(TX_FIFO_DEPTH + 1);

  localparam logic [CNT_W-1:0] CntLast  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CntHalf  = CNT_W'(HALF_BIT - 1);
  localparam logic [BIT_W-1:0] BitLast  = BIT_W'(DATA_BITS - 1);

  // ---------------- synchroniser ----------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;

  always_ff @(posedge clk_i) begin
    if (rst_i) sync_q <= '1;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
  end
  assign rx_s = sync_q[SYNC_STAGES-1];

  // ---------------- RX FSM ----------------
  typedef enum logic [2:0] {
    RxIdle, RxStart, RxData, RxStop, RxWaitHigh
`ifdef COSIM_UART_PARITY_EN
    , RxParity
`endif
  } rx_state_e;

  rx_state_e             rx_state_q, rx_state_d;
  logic [CNT_W-1:0]      rx_cnt_q, rx_cnt_d;
  logic [BIT_W-1:0]      rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0]  rx_shift_q, rx_shift_d;
  logic                  rx_push, frame_err_set;
`ifdef COSIM_UART_PARITY_EN
  logic                  rx_par_bad_q, rx_par_bad_d, parity_err_set, parity_err_q;
`endif

  always_comb begin
    rx_state_d    = rx_state_q;
    rx_cnt_d      = rx_cnt_q;
    rx_bit_d      = rx_bit_q;
    rx_shift_d    = rx_shift_q;
    rx_push       = 1'b0;
    frame_err_set = 1'b0;
`ifdef COSIM_UART_PARITY_EN
    rx_par_bad_d   = rx_par_bad_q;
    parity_err_set = 1'b0;
`endif
    unique case (rx_state_q)
      RxIdle: begin
        if (!rx_s) begin
          rx_state_d = RxStart;
          rx_cnt_d   = '0;
        end
      end
      RxStart: begin
        // Mid-start-bit resample; a line already back high was a glitch.
        if (rx_cnt_q == CntHalf) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_s ? RxIdle : RxData;
`ifdef COSIM_UART_PARITY_EN
          rx_par_bad_d = 1'b0;
`endif
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RxData: begin
        if (rx_cnt_q == CntLast) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s, rx_shift_q[DATA_BITS-1:1]};
          if (rx_bit_q == BitLast) begin
`ifdef COSIM_UART_PARITY_EN
            rx_state_d = RxParity;
`else
            rx_state_d = RxStop;
`endif
          end else begin
            rx_bit_d = rx_bit_q + 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
`ifdef COSIM_UART_PARITY_EN
      RxParity: begin
        if (rx_cnt_q == CntLast) begin
          rx_cnt_d   = '0;
          rx_state_d = RxStop;
          if (rx_s != ^rx_shift_q) begin
            rx_par_bad_d   = 1'b1;
            parity_err_set = 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
`endif
      RxStop: begin
        if (rx_cnt_q == CntLast) begin
          rx_cnt_d = '0;
          if (rx_s) begin
`ifdef COSIM_UART_PARITY_EN
            rx_push = !rx_par_bad_q;
`else
            rx_push = 1'b1;
`endif
            rx_state_d = RxIdle;
          end else begin
            frame_err_set = 1'b1;
            rx_state_d    = RxWaitHigh;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RxWaitHigh: begin
        if (rx_s) rx_state_d = RxIdle;
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_state_q <= RxIdle;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
`ifdef COSIM_UART_PARITY_EN
      rx_par_bad_q <= 1'b0;
`endif
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
`ifdef COSIM_UART_PARITY_EN
      rx_par_bad_q <= rx_par_bad_d;
`endif
    end
  end

  // ---------------- RX FIFO (first-word fall-through) ----------------
  logic [DATA_BITS-1:0] rx_mem_q [RX_FIFO_DEPTH];
  logic [RX_AW-1:0]     rx_wptr_q, rx_rptr_q;
  logic [RX_CW-1:0]     rx_count_q;
  logic                 rx_full, rx_pop, rx_wr, overflow_set;

  assign rx_full      = (rx_count_q == RX_CW'(RX_FIFO_DEPTH));
  assign rx_valid_o   = (rx_count_q != '0);
  assign rx_pop       = rx_valid_o & rx_ready_i;
  assign rx_wr        = rx_push & (!rx_full | rx_pop);
  assign overflow_set = rx_push & rx_full & !rx_pop;
  assign rx_data_o    = rx_valid_o ? rx_mem_q[rx_rptr_q] : '0;
  assign rx_count_o   = rx_count_q;

  always_ff @(posedge clk_i) begin
    if (rx_wr) rx_mem_q[rx_wptr_q] <= rx_shift_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_wptr_q  <= '0;
      rx_rptr_q  <= '0;
      rx_count_q <= '0;
    end else begin
      if (rx_wr)  rx_wptr_q <= rx_wptr_q + 1'b1;
      if (rx_pop) rx_rptr_q <= rx_rptr_q + 1'b1;
      if (rx_wr && !rx_pop)      rx_count_q <= rx_count_q + 1'b1;
      else if (!rx_wr && rx_pop) rx_count_q <= rx_count_q - 1'b1;
    end
  end

  // ---------------- TX FIFO ----------------
  logic [DATA_BITS-1:0] tx_mem_q [TX_FIFO_DEPTH];
  logic [TX_AW-1:0]     tx_wptr_q, tx_rptr_q;
  logic [TX_CW-1:0]     tx_count_q;
  logic                 tx_empty, tx_wr, tx_pop;
  logic [DATA_BITS-1:0] tx_head;

  assign tx_empty   = (tx_count_q == '0);
  assign tx_ready_o = (tx_count_q != TX_CW'(TX_FIFO_DEPTH));
  assign tx_wr      = tx_valid_i & tx_ready_o;
  assign tx_head    = tx_mem_q[tx_rptr_q];

  always_ff @(posedge clk_i) begin
    if (tx_wr) tx_mem_q[tx_wptr_q] <= tx_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_wptr_q  <= '0;
      tx_rptr_q  <= '0;
      tx_count_q <= '0;
    end else begin
      if (tx_wr)  tx_wptr_q <= tx_wptr_q + 1'b1;
      if (tx_pop) tx_rptr_q <= tx_rptr_q + 1'b1;
      if (tx_wr && !tx_pop)      tx_count_q <= tx_count_q + 1'b1;
      else if (!tx_wr && tx_pop) tx_count_q <= tx_count_q - 1'b1;
    end
  end

  // ---------------- TX FSM ----------------
  typedef enum logic [2:0] {
    TxIdle, TxStart, TxData, TxStop
`ifdef COSIM_UART_PARITY_EN
    , TxParity
`endif
  } tx_state_e;

  tx_state_e            tx_state_q, tx_state_d;
  logic [CNT_W-1:0]     tx_cnt_q, tx_cnt_d;
  logic [BIT_W-1:0]     tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_q, tx_d;
`ifdef COSIM_UART_PARITY_EN
  logic                 tx_par_q, tx_par_d;
`endif

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_d       = tx_q;
    tx_pop     = 1'b0;
`ifdef COSIM_UART_PARITY_EN
    tx_par_d   = tx_par_q;
`endif
    unique case (tx_state_q)
      TxIdle, TxStop: begin
        // Leaving STOP with data queued starts the next frame with no idle gap.
        if (tx_state_q == TxIdle || tx_cnt_q == CntLast) begin
          tx_cnt_d = '0;
          if (!tx_empty) begin
            tx_pop     = 1'b1;
            tx_shift_d = tx_head;
            tx_state_d = TxStart;
            tx_d       = 1'b0;
`ifdef COSIM_UART_PARITY_EN
            tx_par_d   = ^tx_head;
`endif
          end else begin
            tx_state_d = TxIdle;
            tx_d       = 1'b1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TxStart: begin
        if (tx_cnt_q == CntLast) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = TxData;
          tx_d       = tx_shift_q[0];
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TxData: begin
        if (tx_cnt_q == CntLast) begin
          tx_cnt_d = '0;
          if (tx_bit_q == BitLast) begin
`ifdef COSIM_UART_PARITY_EN
            tx_state_d = TxParity;
            tx_d       = tx_par_q;
`else
            tx_state_d = TxStop;
            tx_d       = 1'b1;
`endif
          end else begin
            tx_bit_d   = tx_bit_q + 1'b1;
            tx_shift_d = tx_shift_q >> 1;
            tx_d       = tx_shift_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
`ifdef COSIM_UART_PARITY_EN
      TxParity: begin
        if (tx_cnt_q == CntLast) begin
          tx_cnt_d   = '0;
          tx_state_d = TxStop;
          tx_d       = 1'b1;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
`endif
      default: begin
        tx_state_d = TxIdle;
        tx_d       = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_state_q <= TxIdle;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_q       <= 1'b1;
`ifdef COSIM_UART_PARITY_EN
      tx_par_q   <= 1'b0;
`endif
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_q       <= tx_d;
`ifdef COSIM_UART_PARITY_EN
      tx_par_q   <= tx_par_d;
`endif
    end
  end

  assign tx_o      = tx_q;
  assign tx_busy_o = (tx_state_q != TxIdle) | !tx_empty;

  // ---------------- sticky flags (set wins over clear) ----------------
  logic frame_err_q, overflow_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
`ifdef COSIM_UART_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      frame_err_q <= frame_err_set | (frame_err_q & !err_clear_i);
      overflow_q  <= overflow_set | (overflow_q & !err_clear_i);
`ifdef COSIM_UART_PARITY_EN
      parity_err_q <= parity_err_set | (parity_err_q & !err_clear_i);
`endif
    end
  end

  assign frame_err_o = frame_err_q;
  assign overflow_o  = overflow_q;
`ifdef COSIM_UART_PARITY_EN
  assign parity_err_o = parity_err_q;
`endif

endmodule

// File: tb/tb_cosim_uart_link.sv
// Directed self-checking bench for cosim_uart_link (default parameters, 8N1, 5 clocks per bit).
module tb_cosim_uart_link;

  localparam int unsigned CPB  = 5;
  localparam int unsigned SYNC = 3;

  logic       clk = 1'b0;
  logic       rst, rx_line, tx_line, rx_valid, rx_ready, tx_valid, tx_ready, tx_busy;
  logic       frame_err, overflow, err_clear;
  logic [7:0] rx_data, tx_data;
  logic [4:0] rx_count;
`ifdef COSIM_UART_PARITY_EN
  logic       parity_err;
`endif

  int errors = 0;
  int checks = 0;
  logic [7:0] rx_sb[$];
  logic       tx_sb[$];

  always #5 clk = ~clk;

  cosim_uart_link #(
    .CLK_FREQ     (50_000_000),
    .BAUD_RATE    (10_000_000),
    .SYNC_STAGES  (SYNC),
    .DATA_BITS    (8),
    .RX_FIFO_DEPTH(16),
    .TX_FIFO_DEPTH(16)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .rx_i        (rx_line),
    .tx_o        (tx_line),
    .rx_data_o   (rx_data),
    .rx_valid_o  (rx_valid),
    .rx_ready_i  (rx_ready),
    .tx_data_i   (tx_data),
    .tx_valid_i  (tx_valid),
    .tx_ready_o  (tx_ready),
    .rx_count_o  (rx_count),
    .tx_busy_o   (tx_busy),
    .frame_err_o (frame_err),
    .overflow_o  (overflow),
    .err_clear_i (err_clear)
`ifdef COSIM_UART_PARITY_EN
    ,
    .parity_err_o(parity_err)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one frame; rx_line is first seen low by the next clock edge.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rx_line = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 8; i++) begin
      rx_line = b[i];
      repeat (CPB) tick();
    end
    rx_line = stop_bit;
    repeat (CPB) tick();
    rx_line = 1'b1;
  endtask

  task automatic push_tx_expect(input logic [7:0] b);
    repeat (CPB) tx_sb.push_back(1'b0);
    for (int i = 0; i < 8; i++) repeat (CPB) tx_sb.push_back(b[i]);
    repeat (CPB) tx_sb.push_back(1'b1);
  endtask

  task automatic drain(input string tag, output int got);
    logic [7:0] exp;
    got = 0;
    while (rx_valid === 1'b1 && got < 40) begin
      exp = (rx_sb.size() > 0) ? rx_sb.pop_front() : 8'hxx;
      check(tag, rx_data, exp);
      rx_ready = 1'b1;
      tick();
      rx_ready = 1'b0;
      got++;
    end
    check({tag, "_left"}, rx_sb.size(), 0);
  endtask

  initial begin
    int lat, got, n;
    logic [7:0] b;
    logic low_seen;

    rst = 1'b1; rx_line = 1'b1; rx_ready = 1'b0; tx_valid = 1'b0; tx_data = '0; err_clear = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    check("rst_tx", tx_line, 1);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_rx_count", rx_count, 0);
    check("rst_tx_busy", tx_busy, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_overflow", overflow, 0);
    check("rst_rx_data", rx_data, 0);
    repeat (4) tick();

    // 0xA5 reception latency, measured from the first edge that sees the start bit.
    lat = -1;
    rx_sb.push_back(8'hA5);
    fork
      send_frame(8'hA5, 1'b1);
      begin
        for (int k = 1; k <= 70; k++) begin
          tick();
          if (rx_valid === 1'b1 && lat < 0) lat = k - 1;
        end
      end
    join
    $display("rx latency %0d cycles", lat);
    check("rx_latency_window", (lat >= SYNC + 46 && lat <= SYNC + 48) ? 1 : 0, 1);
    check("rx_count_one", rx_count, 1);
    drain("rx_a5", got);
    check("rx_a5_reads", got, 1);

    // TX: 0x3C then 0xFF back to back.
    check("tx_ready_pre", tx_ready, 1);
    tx_valid = 1'b1; tx_data = 8'h3C; push_tx_expect(8'h3C);
    tick();
    tx_data = 8'hFF; push_tx_expect(8'hFF);
    tick();
    tx_valid = 1'b0;
    n = 0;
    while (tx_line !== 1'b0 && n < 20) begin tick(); n++; end
    check("tx_start_seen", tx_line, 0);
    for (int c = 0; c < 100; c++) begin
      check("tx_line", tx_line, tx_sb.pop_front());
      if (c == 99) check("tx_busy_last", tx_busy, 1);
      tick();
    end
    check("tx_busy_done", tx_busy, 0);
    check("tx_idle_high", tx_line, 1);

    // Two-cycle glitch on rx.
    rx_line = 1'b0; tick(); tick(); rx_line = 1'b1;
    repeat (60) tick();
    check("glitch_count", rx_count, 0);
    check("glitch_valid", rx_valid, 0);
    check("glitch_frame_err", frame_err, 0);
    check("glitch_overflow", overflow, 0);

    // Framing error, recovery, then clear.
    send_frame(8'h55, 1'b0);
    repeat (5) tick();
    check("ferr_set", frame_err, 1);
    check("ferr_count", rx_count, 0);
    rx_sb.push_back(8'h12);
    send_frame(8'h12, 1'b1);
    repeat (5) tick();
    check("ferr_recover_count", rx_count, 1);
    check("ferr_sticky", frame_err, 1);
    drain("ferr_rx", got);
    err_clear = 1'b1; tick(); err_clear = 1'b0;
    check("ferr_cleared", frame_err, 0);

    // Overflow: 17 bytes with no consumer.
    for (int i = 0; i < 17; i++) begin
      b = 8'($urandom_range(0, 255));
      if (i < 16) rx_sb.push_back(b);
      send_frame(b, 1'b1);
    end
    repeat (10) tick();
    check("ovf_count", rx_count, 16);
    check("ovf_flag", overflow, 1);
    drain("ovf_rx", got);
    check("ovf_reads", got, 16);
    err_clear = 1'b1; tick(); err_clear = 1'b0;
    check("ovf_cleared", overflow, 0);

    // Reset mid-TX-frame with data in both FIFOs.
    send_frame(8'h5A, 1'b1);
    repeat (5) tick();
    check("pre_rst_rx_count", rx_count, 1);
    tx_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin tx_data = 8'h81 + 8'(i); tick(); end
    tx_valid = 1'b0;
    repeat (20) tick();
    check("pre_rst_tx_busy", tx_busy, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    check("mrst_tx", tx_line, 1);
    check("mrst_tx_ready", tx_ready, 1);
    check("mrst_tx_busy", tx_busy, 0);
    check("mrst_rx_count", rx_count, 0);
    check("mrst_rx_valid", rx_valid, 0);
    low_seen = 1'b0;
    repeat (60) begin
      tick();
      if (tx_line !== 1'b1) low_seen = 1'b1;
    end
    check("mrst_tx_stays_idle", low_seen, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cosim_uart_link.md
Name: cosim_uart_link

Overview:
- Parametrised, buffered UART transceiver for the co-simulation host link.
- Successor of the fixed 3-flop rx synchroniser plus single-rate serial path at the cosim top level. Adds configurable synchroniser depth, data width, bit period, start-bit glitch rejection, RX/TX FIFOs, error flags and optional parity.
- Sits between the board pins (rx_i/tx_o) and the byte-level command controller that drives the mesh loaders and PMUs.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz
BAUD_RATE, 10_000_000, line rate; CLKS_PER_BIT = CLK_FREQ/BAUD_RATE, must be >= 4
SYNC_STAGES, 3, rx_i synchroniser depth, >= 2
DATA_BITS, 8, payload bits per frame, 5..9
RX_FIFO_DEPTH, 16, RX FIFO entries, power of two, >= 2
TX_FIFO_DEPTH, 16, TX FIFO entries, power of two, >= 2

Ports:
clk_i  in  1  system clock
rst_i  in  1  reset, synchronous, active-high
rx_i  in  1  asynchronous serial input, idle high
tx_o  out  1  serial output, idle high
rx_data_o  out  DATA_BITS  head of RX FIFO
rx_valid_o  out  1  RX FIFO not empty
rx_ready_i  in  1  consumer pops RX head when rx_valid_o & rx_ready_i
tx_data_i  in  DATA_BITS  byte to transmit
tx_valid_i  in  1  producer offers tx_data_i
tx_ready_o  out  1  TX FIFO not full; write when tx_valid_i & tx_ready_o
rx_count_o  out  $clog2(RX_FIFO_DEPTH+1)  RX FIFO occupancy
tx_busy_o  out  1  TX FSM not IDLE or TX FIFO not empty
frame_err_o  out  1  sticky: stop bit sampled low
overflow_o  out  1  sticky: received byte dropped, RX FIFO full
err_clear_i  in  1  clears all sticky flags

Behaviour:
- Reset: one clock, synchronous, active-high. Port names clk_i and rst_i.
- While rst_i is high at a clk_i edge: synchroniser flops = all 1, FSMs = IDLE, FIFOs empty, counters 0.
- Outputs after reset: tx_o=1, rx_valid_o=0, tx_ready_o=1, rx_count_o=0, tx_busy_o=0, sticky flags=0, rx_data_o=0.
- Reset mid-frame aborts the frame. A partial RX byte is discarded and TX releases the line high on the next cycle.
- rx_s: last stage of the SYNC_STAGES chain. rx_i to rx_s latency is SYNC_STAGES cycles.
- RX FSM states: IDLE, START, DATA, [PARITY], STOP, WAIT_HIGH.
  - IDLE -> START when rx_s is sampled 0.
  - START: wait CLKS_PER_BIT/2 cycles, then resample. If rx_s=1, treat as a glitch and return to IDLE with no flag. Otherwise go to DATA.
  - DATA: sample once every CLKS_PER_BIT cycles, DATA_BITS samples, LSB first.
  - STOP: sample one bit period later.
    - rx_s=1: push the byte; rx_valid_o rises the next cycle; go to IDLE.
    - rx_s=0: set frame_err_o, discard the byte, go to WAIT_HIGH. WAIT_HIGH -> IDLE when rx_s=1.
- RX FIFO:
  - First-word fall-through.
  - Push and pop in the same cycle are both accepted, even when the FIFO is full; count unchanged.
  - Push while full with no pop: byte dropped, overflow_o set, contents unchanged.
- TX FSM states: IDLE, START, DATA, [PARITY], STOP.
  - IDLE with TX FIFO non-empty: pop the head. tx_o=0 from the next cycle.
  - Every bit, including start and stop, is held exactly CLKS_PER_BIT cycles. Data goes out LSB first; one stop bit at 1.
  - At the end of STOP, if the FIFO is non-empty, the next start bit follows immediately with no idle gap. Otherwise go to IDLE.
  - TX FIFO write while full is ignored; the producer must honour tx_ready_o.
- Sticky flags:
  - err_clear_i clears them next cycle.
  - Set and clear in the same cycle: set wins.
- Frame length: (DATA_BITS+2)*CLKS_PER_BIT cycles.

Optional Feature:
- Macro COSIM_UART_PARITY_EN.
- Defined:
  - Adds an even-parity bit after the data bits in both directions (PARITY state, one bit period).
  - Adds output parity_err_o (1 bit, sticky, same set/clear rules).
  - RX parity mismatch sets parity_err_o and drops the byte. The frame still proceeds to STOP normally.
  - Frame becomes (DATA_BITS+3)*CLKS_PER_BIT cycles.
- Undefined: no PARITY state, no parity_err_o port; 8N1 framing.

Test Plan:
- Default params, after reset: drive 8N1 byte 0xA5 on rx_i at 5 clk/bit -> rx_valid_o rises SYNC_STAGES + 47 ±1 cycles after the start edge; rx_data_o=0xA5; rx_count_o=1.
- Write 0x3C, then 0xFF on TX -> tx_o is low 5 cycles, then bits 0,0,1,1,1,1,0,0 at 5 cycles each, stop high 5 cycles. The second start bit follows with no gap; tx_busy_o drops after 100 cycles total.
- rx_i low pulse of 2 cycles -> no byte, no flags, RX FSM back in IDLE.
- Frame 0x55 with stop bit held 0 -> frame_err_o=1, rx_count_o=0. After the line returns high, 0x12 is received correctly; err_clear_i pulse gives frame_err_o=0.
- Send 17 bytes with rx_ready_i=0 -> rx_count_o=16, overflow_o=1, first 16 bytes read back in order. Byte 17 lost.
- rst_i asserted mid-TX-frame -> tx_o=1 the next cycle, tx_ready_o=1, tx_busy_o=0, FIFOs empty.
